// File: rtl/pc_call_stack_if.sv
// rtl/pc_call_stack_if.sv - command and status bundle between fetch and the PC/call stack
interface pc_call_stack_if #(
    parameter int W     = 16,
    parameter int DEPTH = 8
);
    localparam int SPW = $clog2(DEPTH) + 1;

    logic           cs;
    logic           inc;
    logic           l;
    logic [W-1:0]   load;
    logic           call;
    logic           ret;
    logic           err_clr;
    logic [W-1:0]   DOut;
    logic [SPW-1:0] sp;
    logic           full;
    logic           empty;
    logic           err;

    // Fetch side issues commands and observes the PC and stack status
    modport master (
        output cs, inc, l, load, call, ret, err_clr,
        input  DOut, sp, full, empty, err
    );

    // PC/stack side accepts commands and reports the PC and stack status
    modport slave (
        input  cs, inc, l, load, call, ret, err_clr,
        output DOut, sp, full, empty, err
    );
endinterface

// File: rtl/pc_call_stack.sv
// rtl/pc_call_stack.sv - program counter with return-address stack, step and reset vector
module pc_call_stack #(
    parameter int             W         = 16,
    parameter int             DEPTH     = 8,
    parameter int             STEP      = 1,
    parameter logic [W-1:0]   RESET_VAL = '0
) (
    input  logic          clk,
    input  logic          re,
    pc_call_stack_if.slave bus
);
    localparam int IDXW = $clog2(DEPTH);
    localparam int SPW  = IDXW + 1;

    localparam logic [W-1:0]   STEP_W  = W'(STEP);
    localparam logic [SPW-1:0] DEPTH_W = SPW'(DEPTH);
    localparam logic [SPW-1:0] ONE_SP  = SPW'(1);

    // One action per edge; ret outranks call outranks load outranks inc
    typedef enum logic [2:0] {
        OP_HOLD,
        OP_RET,
        OP_CALL,
        OP_LOAD,
        OP_INC
    } op_e;

    op_e            op;

    logic [W-1:0]   dout_q, dout_d;
    logic [SPW-1:0] sp_q, sp_d;
    logic           err_q, err_d;
    logic [W-1:0]   stack_q [DEPTH];
    logic [W-1:0]   stack_d [DEPTH];

    logic           full_w;
    logic           empty_w;
    logic [SPW-1:0] sp_dec;
    logic [IDXW-1:0] top_idx;
    logic [IDXW-1:0] push_idx;
    logic [W-1:0]   ret_addr;

    // Status is decoded from the registered depth only, so it never glitches with inputs
    assign full_w   = (sp_q == DEPTH_W);
    assign empty_w  = (sp_q == '0);

    // Top-of-stack sits one below sp; the next free slot is at sp itself
    assign sp_dec   = sp_q - ONE_SP;
    assign top_idx  = sp_dec[IDXW-1:0];
    assign push_idx = sp_q[IDXW-1:0];
    assign ret_addr = dout_q + STEP_W;

    // Resolve the single winning command; chip select gates everything
    always_comb begin
        op = OP_HOLD;
        if (bus.cs) begin
            if (bus.ret) begin
                op = OP_RET;
            end else if (bus.call) begin
                op = OP_CALL;
            end else if (bus.l) begin
                op = OP_LOAD;
            end else if (bus.inc) begin
                op = OP_INC;
            end
        end
    end

    // Next-state for PC, depth, stack and sticky error; a fault on the same edge beats err_clr
    always_comb begin
        dout_d  = dout_q;
        sp_d    = sp_q;
        err_d   = err_q;
        stack_d = stack_q;

        if (bus.cs && bus.err_clr) begin
            err_d = 1'b0;
        end

        unique case (op)
            OP_RET: begin
                if (!empty_w) begin
                    dout_d = stack_q[top_idx];
                    sp_d   = sp_dec;
                end else begin
                    err_d  = 1'b1;
                end
            end
            OP_CALL: begin
                // The jump is taken even when the return address cannot be saved
                dout_d = bus.load;
                if (!full_w) begin
                    stack_d[push_idx] = ret_addr;
                    sp_d              = sp_q + ONE_SP;
                end else begin
                    err_d = 1'b1;
                end
            end
            OP_LOAD: begin
                dout_d = bus.load;
            end
            OP_INC: begin
                dout_d = dout_q + STEP_W;
            end
            default: begin
            end
        endcase
    end

    // PC, depth and error flag reset asynchronously; reset empties the stack by clearing sp
    always_ff @(posedge clk or negedge re) begin
        if (!re) begin
            dout_q <= RESET_VAL;
            sp_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            dout_q <= dout_d;
            sp_q   <= sp_d;
            err_q  <= err_d;
        end
    end

    // Stack entries need no reset: nothing above sp is ever read
    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign bus.DOut  = dout_q;
    assign bus.sp    = sp_q;
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_pc_call_stack.sv
// tb/tb_pc_call_stack.sv - table-driven scoreboard bench for pc_call_stack
module tb_pc_call_stack;
    localparam int W     = 16;
    localparam int DEPTH = 8;

    typedef struct {
        string       name;
        bit          cs;
        bit          inc;
        bit          l;
        bit          call;
        bit          ret;
        bit          clr;
        logic [15:0] load;
        logic [15:0] dout;
        int          sp;
        bit          err;
    } vec_t;

    logic clk;
    logic re;
    int   n_checks;
    int   n_errors;
    vec_t tbl[$];
    vec_t exp_q[$];

    pc_call_stack_if #(.W(W), .DEPTH(DEPTH)) bus ();

    pc_call_stack #(.W(W), .DEPTH(DEPTH), .STEP(1), .RESET_VAL(16'h0000)) u_dut (
        .clk (clk),
        .re  (re),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic vec_t mk(string n, bit cs, bit inc, bit l, bit call, bit ret, bit clr,
                                logic [15:0] load, logic [15:0] dout, int sp, bit err);
        vec_t v;
        v.name = n; v.cs = cs; v.inc = inc; v.l = l; v.call = call; v.ret = ret; v.clr = clr;
        v.load = load; v.dout = dout; v.sp = sp; v.err = err;
        return v;
    endfunction

    task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_state(string nm, logic [15:0] dout, int sp, bit err);
        check({nm, ".dout"},  32'(bus.DOut),  32'(dout));
        check({nm, ".sp"},    32'(bus.sp),    32'(sp));
        check({nm, ".err"},   32'(bus.err),   32'(err));
        check({nm, ".full"},  32'(bus.full),  32'(sp == DEPTH));
        check({nm, ".empty"}, 32'(bus.empty), 32'(sp == 0));
    endtask

    task automatic idle();
        bus.cs = 1'b1; bus.inc = 1'b0; bus.l = 1'b0; bus.call = 1'b0;
        bus.ret = 1'b0; bus.err_clr = 1'b0; bus.load = '0;
    endtask

    task automatic run_vec(vec_t v);
        vec_t e;
        @(negedge clk);
        bus.cs = v.cs; bus.inc = v.inc; bus.l = v.l; bus.call = v.call;
        bus.ret = v.ret; bus.err_clr = v.clr; bus.load = v.load;
        exp_q.push_back(v);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            e = exp_q.pop_front();
            check_state(e.name, e.dout, e.sp, e.err);
        end
    endtask

    task automatic run_table();
        foreach (tbl[i]) run_vec(tbl[i]);
        tbl.delete();
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        re = 1'b0;
        idle();
        bus.cs = 1'b0;

        #3;
        check_state("reset", 16'h0000, 0, 1'b0);
        @(posedge clk);
        #1;
        check_state("reset_edge_held", 16'h0000, 0, 1'b0);
        @(negedge clk);
        re = 1'b1;

        //                  name       cs inc l call ret clr load   dout   sp err
        tbl.push_back(mk("inc1",     1, 1, 0, 0, 0, 0, 16'd0,    16'd1,    0, 0));
        tbl.push_back(mk("inc2",     1, 1, 0, 0, 0, 0, 16'd0,    16'd2,    0, 0));
        tbl.push_back(mk("inc3",     1, 1, 0, 0, 0, 0, 16'd0,    16'd3,    0, 0));
        tbl.push_back(mk("inc4",     1, 1, 0, 0, 0, 0, 16'd0,    16'd4,    0, 0));
        tbl.push_back(mk("l_over_inc",1,1, 1, 0, 0, 0, 16'd1000, 16'd1000, 0, 0));
        tbl.push_back(mk("inc5",     1, 1, 0, 0, 0, 0, 16'd0,    16'd1001, 0, 0));
        tbl.push_back(mk("cs0_inc",  0, 1, 0, 0, 0, 0, 16'd0,    16'd1001, 0, 0));
        tbl.push_back(mk("cs0_call", 0, 0, 0, 1, 0, 0, 16'd77,   16'd1001, 0, 0));
        tbl.push_back(mk("call200",  1, 0, 0, 1, 0, 0, 16'd200,  16'd200,  1, 0));
        tbl.push_back(mk("inc201",   1, 1, 0, 0, 0, 0, 16'd0,    16'd201,  1, 0));
        tbl.push_back(mk("call500",  1, 1, 1, 1, 0, 0, 16'd500,  16'd500,  2, 0));
        tbl.push_back(mk("ret202",   1, 0, 0, 0, 1, 0, 16'd0,    16'd202,  1, 0));
        tbl.push_back(mk("ret1002",  1, 0, 0, 0, 1, 0, 16'd0,    16'd1002, 0, 0));
        run_table();

        for (int i = 0; i < DEPTH; i++) begin
            tbl.push_back(mk($sformatf("ovf_call%0d", i), 1, 0, 0, 1, 0, 0,
                             16'(10 + i), 16'(10 + i), i + 1, 0));
        end
        tbl.push_back(mk("ovf_call_full", 1, 0, 0, 1, 0, 0, 16'd99, 16'd99, DEPTH, 1));
        for (int k = 0; k < DEPTH; k++) begin
            tbl.push_back(mk($sformatf("ovf_ret%0d", k), 1, 0, 0, 0, 1, 0, 16'd0,
                             (k == DEPTH - 1) ? 16'd1003 : 16'(17 - k), DEPTH - 1 - k, 1));
        end
        run_table();

        tbl.push_back(mk("clr_after_ovf", 1, 0, 0, 0, 0, 1, 16'd0,  16'd1003, 0, 0));
        tbl.push_back(mk("load7",         1, 0, 1, 0, 0, 0, 16'd7,  16'd7,    0, 0));
        tbl.push_back(mk("unf_ret",       1, 0, 0, 0, 1, 0, 16'd0,  16'd7,    0, 1));
        tbl.push_back(mk("cs0_clr",       0, 0, 0, 0, 0, 1, 16'd0,  16'd7,    0, 1));
        tbl.push_back(mk("clr",           1, 0, 0, 0, 0, 1, 16'd0,  16'd7,    0, 0));
        tbl.push_back(mk("clr_and_unf",   1, 0, 0, 0, 1, 1, 16'd0,  16'd7,    0, 1));
        tbl.push_back(mk("hold_err",      1, 0, 0, 0, 0, 0, 16'd0,  16'd7,    0, 1));
        tbl.push_back(mk("ret_over_call", 1, 0, 0, 1, 1, 1, 16'd300,16'd7,    0, 1));
        tbl.push_back(mk("clr2",          1, 0, 0, 0, 0, 1, 16'd0,  16'd7,    0, 0));
        tbl.push_back(mk("call300",       1, 0, 0, 1, 0, 0, 16'd300,16'd300,  1, 0));
        tbl.push_back(mk("ret_wins_all",  1, 1, 1, 1, 1, 0, 16'd5,  16'd8,    0, 0));
        tbl.push_back(mk("load_ffff",     1, 0, 1, 0, 0, 0, 16'hFFFF,16'hFFFF,0, 0));
        tbl.push_back(mk("inc_wrap",      1, 1, 0, 0, 0, 0, 16'd0,  16'h0000, 0, 0));
        tbl.push_back(mk("load_ffff2",    1, 0, 1, 0, 0, 0, 16'hFFFF,16'hFFFF,0, 0));
        tbl.push_back(mk("call_wrap_ret", 1, 0, 0, 1, 0, 0, 16'd40, 16'd40,   1, 0));
        tbl.push_back(mk("ret_wrapped",   1, 0, 0, 0, 1, 0, 16'd0,  16'h0000, 0, 0));
        tbl.push_back(mk("call40",        1, 0, 0, 1, 0, 0, 16'd40, 16'd40,   1, 0));
        tbl.push_back(mk("call50",        1, 0, 0, 1, 0, 0, 16'd50, 16'd50,   2, 0));
        run_table();

        // Asynchronous reset pulse between edges, with a call queued on the inputs
        #2;
        bus.call = 1'b1;
        bus.load = 16'd60;
        re = 1'b0;
        #1;
        check_state("async_reset", 16'h0000, 0, 1'b0);
        idle();
        re = 1'b1;

        tbl.push_back(mk("ret_after_reset", 1, 0, 0, 0, 1, 0, 16'd0, 16'h0000, 0, 1));
        tbl.push_back(mk("inc_after_reset", 1, 1, 0, 0, 0, 0, 16'd0, 16'h0001, 0, 1));
        run_table();

        if (exp_q.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/pc_call_stack.md
Name: pc_call_stack

Overview:
- Parametrised successor to the 16-bit program counter: a PC register with reset, increment and load.
- Adds a hardware return-address stack (call/return), a configurable increment step and a configurable reset vector.
- Adds status flags for stack full/empty and a sticky error flag.
- Sits between instruction fetch and the RAM16K address port; dout drives the fetch address.

Parameters:
W, 16, PC/data width in bits
DEPTH, 8, return-stack entries (power of two, 2..64)
STEP, 1, increment amount added on inc and pushed as return offset
RESET_VAL, 0, PC value after reset (W bits)

Ports:
clk  input  1  clock; all state updates on rising edge
re  input  1  asynchronous active-low reset
cs  input  1  chip select; when 0 all state holds and no command is taken
inc  input  1  advance PC by STEP
l  input  1  load PC from load
load  input  W  load/call target
call  input  1  push PC+STEP, jump to load
ret  input  1  pop top of stack into PC
err_clr  input  1  clear sticky err
DOut  output  W  current PC (registered)
sp  output  $clog2(DEPTH)+1  number of valid stack entries
full  output  1  sp == DEPTH
empty  output  1  sp == 0
err  output  1  sticky overflow/underflow flag

Behaviour:
- Reset (re=0, asynchronous, immediate, independent of clk):
  - DOut=RESET_VAL, sp=0, err=0, so empty=1, full=0.
  - Stack contents are don't-care and are never read while empty.
- Release of re takes effect at the next rising edge. No command is honoured on the edge coincident with deassertion if re is still low at that edge.
- Every command is sampled on the rising edge when re=1 and cs=1. Results are visible on DOut/sp/flags after that edge (1-cycle latency, no combinational path from inputs to DOut).
- Fixed priority, one action per cycle: ret > call > l > inc > hold. Lower-priority commands asserted in the same cycle are ignored.
- ret:
  - If not empty: DOut <= stack[sp-1], sp <= sp-1.
  - If empty: underflow; DOut holds, sp stays 0, err <= 1.
- call:
  - If not full: stack[sp] <= DOut+STEP (mod 2^W), sp <= sp+1, DOut <= load.
  - If full: overflow; DOut <= load (jump still taken), stack and sp unchanged, err <= 1.
- l: DOut <= load; stack untouched.
- inc: DOut <= DOut+STEP, truncated to W bits (wraps past 2^W-1 to low bits).
- hold: all state unchanged.
- err_clr:
  - Clears err on the edge when cs=1.
  - If an overflow/underflow occurs on the same edge, set wins (err stays 1).
- cs=0: all commands, including err_clr, are ignored.
- full and empty are decoded combinationally from registered sp; they are never both 1.
- Stack storage is a register array indexed by sp; no RAM macro.
- Reset mid-operation (for example, between a call and its ret) discards all stack entries; a subsequent ret is an underflow.

Test Plan:
1. Reset/inc: hold re=0 for 5 time units, then re=1, cs=1, inc=1 for 4 edges -> DOut 0,1,2,3,4 (STEP=1); sp=0, empty=1 throughout.
2. Load/priority: DOut=4; l=1, inc=1, load=1000 -> DOut=1000 (l beats inc). Next edge inc only -> 1001. Then cs=0 with inc=1 -> DOut stays 1001.
3. Call/return nesting: DOut=1001; call load=200 -> DOut=200, sp=1. inc -> 201. call load=500 -> DOut=500, sp=2. ret -> DOut=202, sp=1. ret -> DOut=1002, sp=0, empty=1, err=0.
4. Overflow (DEPTH=8): 8 calls with load=10..17 -> sp=8, full=1. 9th call load=99 -> DOut=99, sp=8, err=1. Then 8 rets return the pushed addresses in reverse order (last is 11, first pushed is 1003 if starting at 1002).
5. Underflow and err clear: empty stack with DOut=7; ret -> DOut=7, err=1. err_clr=1 -> err=0. err_clr=1 together with ret on empty -> err=1 (set wins).
6. Wrap/async reset: load 16'hFFFF then inc -> DOut=0. Call twice, then pulse re=0 between clock edges -> DOut=RESET_VAL and sp=0 immediately, before the next edge; following ret -> err=1.
